// File: rtl/idli_pkg.sv
// Shared types and opcodes for the SQI block-RAM responder.
// The responder's state encoding is exported here so benches can decode its debug output.
package idli_pkg;

  localparam logic [7:0] SQI_OP_READ_C  = 8'h03;
  localparam logic [7:0] SQI_OP_WRITE_C = 8'h02;

  typedef logic [3:0] slice_t;

  typedef enum logic [2:0] {
    IDLE,
    INSTR,
    ADDR,
    DUMMY,
    READ,
    WRITE,
    IGNORE
  } sqi_state_t;

endpackage

// File: rtl/idli_tb_bram_m.sv
// Byte-wide single-port synchronous RAM with a one-cycle registered read.
// The read is read-first, so a same-cycle write returns the old byte.
module idli_tb_bram_m #(
  parameter int DEPTH_BYTES = 131072,
  parameter     INIT_FILE   = "",
  localparam int AW         = $clog2(DEPTH_BYTES)
) (
  input  logic          i_clk,
  input  logic [AW-1:0] i_addr,
  input  logic          i_we,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] mem_q [DEPTH_BYTES];
  logic [7:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_addr] <= i_wdata;
    end
    rdata_q <= mem_q[i_addr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/idli_tb_sqi_bram_m.sv
// SQI SRAM responder (READ 0x03 / WRITE 0x02, sequential mode) backed by block RAM.
// SCK is treated as data sampled on the core clock; edges are found by comparing with sck_prev_q.
module idli_tb_sqi_bram_m
  import idli_pkg::*;
#(
  parameter int DEPTH_BYTES  = 131072,
  parameter int DUMMY_CYCLES = 2,
  parameter     INIT_FILE    = ""
) (
  input  logic       i_bram_gck,
  input  logic       i_bram_rst,
  input  logic       i_sqi_sck,
  input  logic       i_sqi_cs,
  input  slice_t     i_sqi_sio,
  output slice_t     o_sqi_sio,
  output logic       o_sqi_en,
  output sqi_state_t o_dbg_state
);

  localparam int AW = $clog2(DEPTH_BYTES);

  // Handshake: the initiator owns SCK and CS. Input nibbles are taken on the core cycle that
  // sees an SCK rise; output nibbles change on the cycle that sees an SCK fall, giving the
  // initiator a full half-period of setup before its next rise. CS high aborts everything.

  sqi_state_t    state_q, state_d;
  logic          sck_prev_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    instr_q, instr_d;
  logic [AW-1:0] addr_q, addr_d;
  slice_t        wr_hi_q, wr_hi_d;
  logic          nib_hi_q, nib_hi_d;
  slice_t        sio_q, sio_d;
  logic          en_q, en_d;

  logic          sck_rise, sck_fall;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;
  logic [AW-1:0] addr_inc;

  assign sck_rise = i_sqi_sck & ~sck_prev_q;
  assign sck_fall = ~i_sqi_sck & sck_prev_q;
  assign addr_inc = (addr_q == AW'(DEPTH_BYTES - 1)) ? '0 : addr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    wr_hi_d   = wr_hi_q;
    nib_hi_d  = nib_hi_q;
    sio_d     = sio_q;
    en_d      = en_q;
    ram_we    = 1'b0;
    ram_wdata = {wr_hi_q, i_sqi_sio};

    if (i_sqi_cs) begin
      state_d  = IDLE;
      cnt_d    = '0;
      nib_hi_d = 1'b1;
      sio_d    = '0;
      en_d     = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // A rise in the same cycle as CS falling is already the first opcode nibble.
          state_d = INSTR;
          cnt_d   = '0;
          if (sck_rise) begin
            instr_d = {instr_q[3:0], i_sqi_sio};
            cnt_d   = 4'd1;
          end
        end
        INSTR: begin
          if (sck_rise) begin
            instr_d = {instr_q[3:0], i_sqi_sio};
            if (cnt_q == 4'd1) begin
              cnt_d   = '0;
              state_d = (instr_d == SQI_OP_READ_C || instr_d == SQI_OP_WRITE_C) ? ADDR : IGNORE;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        ADDR: begin
          if (sck_rise) begin
            addr_d = {addr_q[AW-5:0], i_sqi_sio};
            if (cnt_q == 4'd5) begin
              cnt_d    = '0;
              nib_hi_d = 1'b1;
              if (instr_q == SQI_OP_READ_C) begin
                state_d = (DUMMY_CYCLES == 0) ? READ : DUMMY;
              end else begin
                state_d = WRITE;
              end
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        DUMMY: begin
          // The RAM is already reading addr_q, so the first byte is ready long before the first fall.
          if (sck_rise) begin
            if (cnt_q == 4'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = READ;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end
        end
        READ: begin
          if (sck_fall) begin
            en_d = 1'b1;
            if (nib_hi_q) begin
              sio_d    = ram_rdata[7:4];
              nib_hi_d = 1'b0;
            end else begin
              // The address steps here; the next byte arrives while this low nibble is presented.
              sio_d    = ram_rdata[3:0];
              nib_hi_d = 1'b1;
              addr_d   = addr_inc;
            end
          end
        end
        WRITE: begin
          if (sck_rise) begin
            if (nib_hi_q) begin
              wr_hi_d  = i_sqi_sio;
              nib_hi_d = 1'b0;
            end else begin
              ram_we   = ~i_bram_rst;
              nib_hi_d = 1'b1;
              addr_d   = addr_inc;
            end
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_bram_gck) begin
    if (i_bram_rst) begin
      state_q    <= IDLE;
      sck_prev_q <= 1'b0;
      cnt_q      <= '0;
      instr_q    <= '0;
      addr_q     <= '0;
      wr_hi_q    <= '0;
      nib_hi_q   <= 1'b1;
      sio_q      <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sck_prev_q <= i_sqi_sck;
      cnt_q      <= cnt_d;
      instr_q    <= instr_d;
      addr_q     <= addr_d;
      wr_hi_q    <= wr_hi_d;
      nib_hi_q   <= nib_hi_d;
      sio_q      <= sio_d;
      en_q       <= en_d;
    end
  end

  idli_tb_bram_m #(
    .DEPTH_BYTES (DEPTH_BYTES),
    .INIT_FILE   (INIT_FILE)
  ) u_bram (
    .i_clk   (i_bram_gck),
    .i_addr  (addr_q),
    .i_we    (ram_we),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  assign o_sqi_sio   = sio_q;
  assign o_sqi_en    = en_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_idli_tb_sqi_bram_m.sv
// Directed bench for the SQI block-RAM responder: an SQI initiator driver plus a nibble scoreboard.
module tb_idli_tb_sqi_bram_m;
  import idli_pkg::*;

  localparam int DEPTH = 131072;
  localparam int DUMMY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs;
  slice_t     sio_in;
  slice_t     sio_out;
  logic       en_out;
  sqi_state_t dbg_state;

  logic [3:0] exp_q[$];
  int         n_total = 0;
  int         n_bad   = 0;
  logic       en_early;

  idli_tb_sqi_bram_m #(
    .DEPTH_BYTES  (DEPTH),
    .DUMMY_CYCLES (DUMMY),
    .INIT_FILE    ("")
  ) dut (
    .i_bram_gck  (clk),
    .i_bram_rst  (rst),
    .i_sqi_sck   (sck),
    .i_sqi_cs    (cs),
    .i_sqi_sio   (sio_in),
    .o_sqi_sio   (sio_out),
    .o_sqi_en    (en_out),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // SCK half-periods shorter than two core cycles are outside the responder's operating range.
  logic sck_seen = 1'b0;
  int   half_len = 100;
  always @(posedge clk) begin
    if (sck !== sck_seen) begin
      if (half_len < 2) begin
        n_bad++;
        $display("FAIL sck_half_period got=%0d exp>=2", half_len);
      end
      half_len = 1;
      sck_seen = sck;
    end else begin
      half_len++;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic exp_byte(input logic [7:0] b);
    exp_q.push_back(b[7:4]);
    exp_q.push_back(b[3:0]);
  endtask

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCK period: drive a nibble, sample the responder just before the rise.
  task automatic pulse(input slice_t nib, output slice_t got, output logic en);
    sio_in = nib;
    tick(3);
    got = sio_out;
    en  = en_out;
    sck = 1'b1;
    tick(3);
    sck = 1'b0;
  endtask

  task automatic send_nib(input slice_t nib);
    slice_t g;
    logic   e;
    pulse(nib, g, e);
    if (e) en_early = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[7:4]);
    send_nib(b[3:0]);
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) send_nib(a[i*4 +: 4]);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    tick(2);
  endtask

  task automatic cs_high();
    tick(2);
    cs = 1'b1;
    tick(2);
  endtask

  task automatic sqi_write(input logic [23:0] a, input logic [7:0] b0, input logic [7:0] b1,
                           input int n);
    cs_low();
    send_byte(SQI_OP_WRITE_C);
    send_addr(a);
    send_byte(b0);
    if (n > 1) send_byte(b1);
    cs_high();
  endtask

  task automatic read_data(input string tag, input int nnib);
    slice_t g;
    logic   e;
    logic [3:0] x;
    for (int i = 0; i < nnib; i++) begin
      pulse(4'h0, g, e);
      x = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
      chk({tag, "_nib"}, 32'(g), 32'(x));
      chk({tag, "_en"}, 32'(e), 32'd1);
    end
  endtask

  task automatic sqi_read(input string tag, input logic [23:0] a, input int nbytes);
    en_early = 1'b0;
    cs_low();
    send_byte(SQI_OP_READ_C);
    send_addr(a);
    repeat (DUMMY) send_nib(4'h0);
    read_data(tag, 2 * nbytes);
    chk({tag, "_en_early"}, 32'(en_early), 32'd0);
    cs_high();
    chk({tag, "_en_after"}, 32'(en_out), 32'd0);
    chk({tag, "_sio_after"}, 32'(sio_out), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; cs = 1'b1; sck = 1'b0; sio_in = 4'h0;
    tick(4);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_en", 32'(en_out), 32'd0);
    chk("rst_sio", 32'(sio_out), 32'd0);
    rst = 1'b0;
    tick(2);

    // Basic read of a preloaded pair.
    sqi_write(24'h000010, 8'hA5, 8'h3C, 2);
    exp_byte(8'hA5); exp_byte(8'h3C);
    sqi_read("rd10", 24'h000010, 2);

    // Write two bytes between known neighbours.
    sqi_write(24'h00001F, 8'h55, 8'h00, 1);
    sqi_write(24'h000022, 8'hAA, 8'h00, 1);
    sqi_write(24'h000020, 8'h12, 8'h34, 2);
    exp_byte(8'h55); exp_byte(8'h12); exp_byte(8'h34); exp_byte(8'hAA);
    sqi_read("rd1f", 24'h00001F, 4);

    // Write and read across the top of storage.
    sqi_write(24'h01FFFF, 8'h7E, 8'h81, 2);
    exp_byte(8'h7E); exp_byte(8'h81);
    sqi_read("wrap", 24'h01FFFF, 2);

    // Address bits above the storage width are ignored.
    exp_byte(8'hA5);
    sqi_read("hiaddr", 24'hFE0010, 1);

    // Partial second byte aborted by CS.
    sqi_write(24'h000031, 8'hC3, 8'h00, 1);
    cs_low();
    send_byte(SQI_OP_WRITE_C);
    send_addr(24'h000030);
    send_byte(8'h9F);
    send_nib(4'h6);
    cs_high();
    exp_byte(8'h9F); exp_byte(8'hC3);
    sqi_read("partial", 24'h000030, 2);

    // Unknown opcode: nothing driven, nothing written.
    sqi_write(24'h000040, 8'h11, 8'h00, 1);
    en_early = 1'b0;
    cs_low();
    send_byte(8'hFF);
    send_addr(24'h000040);
    send_byte(8'h77);
    chk("ign_state", 32'(dbg_state), 32'(IGNORE));
    chk("ign_en", 32'(en_early), 32'd0);
    cs_high();
    exp_byte(8'h11);
    sqi_read("after_ign", 24'h000040, 1);

    // Reset in the middle of a read.
    en_early = 1'b0;
    cs_low();
    send_byte(SQI_OP_READ_C);
    send_addr(24'h000010);
    repeat (DUMMY) send_nib(4'h0);
    exp_byte(8'hA5);
    read_data("mid", 2);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    chk("mid_rst_en", 32'(en_out), 32'd0);
    chk("mid_rst_sio", 32'(sio_out), 32'd0);
    rst = 1'b0;
    cs = 1'b1;
    tick(3);
    exp_byte(8'h3C);
    sqi_read("post_rst", 24'h000011, 1);

    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
